round_robin_arbiter_9: RTL and testbench

Nine-requester round-robin arbiter that shares a single downstream resource, for example a shared bus or the condition-evaluation datapath, among up to nine sources. Per-input request polarity is set by a `BubblesMask` parameter, using the same bubble convention as the codebase's wide gates. The arbiter issues one registered one-hot grant and holds it until the owner releases. It sits between the requesting blocks and the shared resource's select/enable inputs.

---
 rtl/round_robin_arbiter_9_pkg.sv | 26 ++
 rtl/round_robin_arbiter_9_pick.sv | 35 +++
 rtl/round_robin_arbiter_9.sv | 141 ++++++++++++++
 tb/tb_round_robin_arbiter_9.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_9_pkg.sv
// Shared constants, state encoding and pointer helper for the nine-way round-robin arbiter.
// Optional feature macro: RRARB_HOLD_TIMEOUT_EN (enables the hold-limit timeout).
package round_robin_arbiter_9_pkg;

  localparam int unsigned RRARB_NUM_REQ = 9;
  localparam int unsigned RRARB_IDX_W   = 4;
  localparam int unsigned RRARB_HOLD_W  = 8;

  localparam logic [RRARB_IDX_W-1:0] RRARB_IDX_NONE = 4'd15;

  typedef enum logic {
    RRARB_ST_IDLE  = 1'b0,
    RRARB_ST_GRANT = 1'b1
  } rrarb_state_e;

  // Advance a requester index by one, wrapping 8 -> 0.
  function automatic logic [RRARB_IDX_W-1:0] rrarb_next_ptr(input logic [RRARB_IDX_W-1:0] idx);
    logic [RRARB_IDX_W-1:0] nxt;
    nxt = idx + RRARB_IDX_W'(1);
    if (idx >= RRARB_IDX_W'(RRARB_NUM_REQ - 1)) begin
      nxt = '0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_9_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, modulo 9.
module rr_pick_9
  import round_robin_arbiter_9_pkg::*;
(
  input  logic [RRARB_NUM_REQ-1:0] req_eff,
  input  logic [RRARB_IDX_W-1:0]   ptr,
  output logic [RRARB_NUM_REQ-1:0] winner_onehot,
  output logic [RRARB_IDX_W-1:0]   winner_idx,
  output logic                     any
);

  // Scan the nine positions starting at ptr; the first hit wins.
  always_comb begin
    logic       found;
    logic [4:0] pos;
    winner_onehot = '0;
    winner_idx    = RRARB_IDX_NONE;
    found         = 1'b0;
    pos           = '0;
    for (int unsigned k = 0; k < RRARB_NUM_REQ; k++) begin
      pos = 5'(ptr) + 5'(k);
      if (pos >= 5'(RRARB_NUM_REQ)) begin
        pos = pos - 5'(RRARB_NUM_REQ);
      end
      if (!found && req_eff[pos[3:0]]) begin
        found                     = 1'b1;
        winner_onehot[pos[3:0]]   = 1'b1;
        winner_idx                = pos[3:0];
      end
    end
  end

  assign any = |req_eff;

endmodule

// File: rtl/round_robin_arbiter_9.sv
// Nine-requester round-robin arbiter with registered one-hot grant held until release.
// Optional feature macro: RRARB_HOLD_TIMEOUT_EN (revokes a grant after MaxHold cycles).
module round_robin_arbiter_9
  import round_robin_arbiter_9_pkg::*;
#(
  parameter logic [RRARB_NUM_REQ-1:0] BubblesMask = '0,
  parameter int unsigned              MaxHold     = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [RRARB_NUM_REQ-1:0] Request,
  output logic [RRARB_NUM_REQ-1:0] Grant,
  output logic                     GrantValid,
  output logic [RRARB_IDX_W-1:0]   GrantIndex,
  output logic                     Timeout
);

  if ((MaxHold < 2) || (MaxHold > 255)) begin : g_maxhold_range
    $error("MaxHold must be within 2..255");
  end

  logic [RRARB_NUM_REQ-1:0] req_eff;
  logic [RRARB_NUM_REQ-1:0] pick_onehot;
  logic [RRARB_IDX_W-1:0]   pick_idx;
  logic                     pick_any;
  logic                     owner_req;

  rrarb_state_e             state_q, state_d;
  logic [RRARB_IDX_W-1:0]   ptr_q, ptr_d;
  logic [RRARB_NUM_REQ-1:0] grant_q, grant_d;
  logic                     valid_q, valid_d;
  logic [RRARB_IDX_W-1:0]   idx_q, idx_d;

`ifdef RRARB_HOLD_TIMEOUT_EN
  localparam logic [RRARB_HOLD_W-1:0] HoldLast = RRARB_HOLD_W'(MaxHold - 1);
  logic [RRARB_HOLD_W-1:0] hold_q, hold_d;
  logic                    tmo_q, tmo_d;
`endif

  assign req_eff   = Request ^ BubblesMask;
  assign owner_req = |(req_eff & grant_q);

  rr_pick_9 u_pick (
    .req_eff       (req_eff),
    .ptr           (ptr_q),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .any           (pick_any)
  );

  // Next-state: grant the scan winner from IDLE; drop on release (or hold limit).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
`ifdef RRARB_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      RRARB_ST_IDLE: begin
        if (pick_any) begin
          state_d = RRARB_ST_GRANT;
          grant_d = pick_onehot;
          valid_d = 1'b1;
          idx_d   = pick_idx;
          ptr_d   = rrarb_next_ptr(pick_idx);
`ifdef RRARB_HOLD_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      RRARB_ST_GRANT: begin
        if (!owner_req) begin
          state_d = RRARB_ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          idx_d   = RRARB_IDX_NONE;
        end
`ifdef RRARB_HOLD_TIMEOUT_EN
        else if (hold_q == HoldLast) begin
          state_d = RRARB_ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          idx_d   = RRARB_IDX_NONE;
          tmo_d   = 1'b1;
        end else begin
          hold_d  = hold_q + RRARB_HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = RRARB_ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        idx_d   = RRARB_IDX_NONE;
      end
    endcase
  end

  // State, pointer and output registers; reset drops any grant immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= RRARB_ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= RRARB_IDX_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RRARB_HOLD_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
    end
  end

  assign Timeout = tmo_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Grant      = grant_q;
  assign GrantValid = valid_q;
  assign GrantIndex = idx_q;

endmodule

// File: tb/tb_round_robin_arbiter_9.sv
// Self-checking bench for round_robin_arbiter_9 against a behavioural owner/pointer model.
// Optional feature macro: RRARB_HOLD_TIMEOUT_EN (selects the timeout scenario).
module tb_round_robin_arbiter_9;

  localparam logic [8:0] MASK = 9'h100;
  localparam int         MAXH = 4;
`ifdef RRARB_HOLD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [8:0] Request;
  logic [8:0] Grant;
  logic       GrantValid;
  logic [3:0] GrantIndex;
  logic       Timeout;

  int total = 0;
  int bad   = 0;

  // Model: current owner (-1 idle), scan start, visible grant length, timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_len   = 0;
  bit m_tmo   = 1'b0;

  round_robin_arbiter_9 #(
    .BubblesMask (MASK),
    .MaxHold     (MAXH)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Request    (Request),
    .Grant      (Grant),
    .GrantValid (GrantValid),
    .GrantIndex (GrantIndex),
    .Timeout    (Timeout)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_len   = 0;
    m_tmo   = 1'b0;
  endfunction

  // One clock edge of the arbitration rules, given the effective requests seen at that edge.
  function automatic void model_update(input logic [8:0] eff);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 9; k++) begin
        int i;
        i = (m_ptr + k) % 9;
        if (m_owner < 0 && eff[i]) begin
          m_owner = i;
          m_ptr   = (i + 1) % 9;
          m_len   = 1;
        end
      end
    end else if (!eff[m_owner]) begin
      m_owner = -1;
    end else if (TMO_EN && m_len >= MAXH) begin
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_len++;
    end
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [8:0] g;
    logic [3:0] ix;
    g  = '0;
    ix = 4'd15;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      ix         = 4'(m_owner);
    end
    return {g, (m_owner >= 0), ix, m_tmo};
  endfunction

  function automatic logic [14:0] obs();
    return {Grant, GrantValid, GrantIndex, Timeout};
  endfunction

  task automatic set_eff(input logic [8:0] eff);
    Request = eff ^ MASK;
  endtask

  task automatic step();
    logic [8:0] e;
    e = Request ^ MASK;
    @(posedge Clock);
    model_update(e);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_eff(9'h000);
    #3;
    total++;
    if (obs() !== {9'h000, 1'b0, 4'd15, 1'b0}) begin
      $display("FAIL reset_async got=%h want=%h", obs(), {9'h000, 1'b0, 4'd15, 1'b0});
      bad++;
    end
    set_eff(9'h1FF);
    @(posedge Clock);
    #1;
    total++;
    if (obs() !== {9'h000, 1'b0, 4'd15, 1'b0}) begin
      $display("FAIL reset_held got=%h want=%h", obs(), {9'h000, 1'b0, 4'd15, 1'b0});
      bad++;
    end
    set_eff(9'h000);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    set_eff(9'h004);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h004 || GrantIndex !== 4'd2) begin
      $display("FAIL single_grant got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    step();
    total++;
    if (obs() !== exp_vec()) begin
      $display("FAIL single_hold got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    // Owner 2 releases while 0 and 3 request: release first, then 3 wins since ptr is 3.
    set_eff(9'h009);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h000) begin
      $display("FAIL single_release got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    step();
    total++;
    if (obs() !== exp_vec() || GrantIndex !== 4'd3) begin
      $display("FAIL single_ptr3 got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    set_eff(9'h000);
    step();
    total++;
    if (obs() !== exp_vec()) begin
      $display("FAIL single_idle got=%h want=%h", obs(), exp_vec());
      bad++;
    end
  endtask

  task automatic test_rotation();
    int         ngr;
    int         idle_run;
    logic       prev_valid;
    logic [8:0] e;
    ngr        = 0;
    idle_run   = 0;
    prev_valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      e = 9'h1FF;
      if (m_owner >= 0 && m_len >= 2) e[m_owner] = 1'b0;
      set_eff(e);
      step();
      total++;
      if (obs() !== exp_vec()) begin
        $display("FAIL rot_cycle c=%0d got=%h want=%h", c, obs(), exp_vec());
        bad++;
      end
      if (GrantValid === 1'b1) begin
        if (prev_valid !== 1'b1) begin
          total++;
          if (GrantIndex !== 4'(ngr % 9)) begin
            $display("FAIL rot_order n=%0d got=%0d want=%0d", ngr, GrantIndex, ngr % 9);
            bad++;
          end
          if (ngr > 0) begin
            total++;
            if (idle_run !== 1) begin
              $display("FAIL rot_gap n=%0d got=%0d want=1", ngr, idle_run);
              bad++;
            end
          end
          ngr++;
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_valid = GrantValid;
    end
    total++;
    if (ngr !== 10) begin
      $display("FAIL rot_count got=%0d want=10", ngr);
      bad++;
    end
  endtask

  task automatic test_polarity();
    Request = 9'h100;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs() !== exp_vec() || Grant !== 9'h000) begin
        $display("FAIL pol_inactive i=%0d got=%h want=%h", i, obs(), exp_vec());
        bad++;
      end
    end
    Request = 9'h000;
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h100 || GrantIndex !== 4'd8) begin
      $display("FAIL pol_active got=%h want=%h", obs(), exp_vec());
      bad++;
    end
  endtask

  task automatic test_no_preempt_wrap();
    set_eff(9'h101);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h100) begin
      $display("FAIL nopre_hold got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    set_eff(9'h001);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h000) begin
      $display("FAIL nopre_idle got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h001 || GrantIndex !== 4'd0) begin
      $display("FAIL nopre_wrap got=%h want=%h", obs(), exp_vec());
      bad++;
    end
  endtask

  task automatic test_timeout();
    int cnt5;
    cnt5 = 0;
    set_eff(9'h000);
    step();
    set_eff(9'h060);
`ifdef RRARB_HOLD_TIMEOUT_EN
    for (int s = 1; s <= 6; s++) begin
      step();
      total++;
      if (obs() !== exp_vec()) begin
        $display("FAIL tmo_cycle s=%0d got=%h want=%h", s, obs(), exp_vec());
        bad++;
      end
      if (s <= 5 && Grant === 9'h020) cnt5++;
      if (s == 5) begin
        total++;
        if (Timeout !== 1'b1 || Grant !== 9'h000) begin
          $display("FAIL tmo_pulse got=%b/%h want=1/000", Timeout, Grant);
          bad++;
        end
      end
      if (s == 6) begin
        total++;
        if (Grant !== 9'h040 || Timeout !== 1'b0) begin
          $display("FAIL tmo_next got=%h/%b want=040/0", Grant, Timeout);
          bad++;
        end
      end
    end
    total++;
    if (cnt5 !== 4) begin
      $display("FAIL tmo_len got=%0d want=4", cnt5);
      bad++;
    end
`else
    for (int s = 1; s <= 12; s++) begin
      step();
      total++;
      if (obs() !== exp_vec()) begin
        $display("FAIL hold_cycle s=%0d got=%h want=%h", s, obs(), exp_vec());
        bad++;
      end
      if (Grant === 9'h020) cnt5++;
    end
    total++;
    if (cnt5 !== 12) begin
      $display("FAIL hold_len got=%0d want=12", cnt5);
      bad++;
    end
`endif
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int c = 0; c < 300; c++) begin
      e = 9'($urandom_range(0, 511));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) e[m_owner] = 1'b1;
      set_eff(e);
      step();
      total++;
      if (obs() !== exp_vec()) begin
        $display("FAIL rand c=%0d req=%h got=%h want=%h", c, e, obs(), exp_vec());
        bad++;
      end
    end
  endtask

  task automatic test_async_reset();
    set_eff(9'h000);
    step();
    step();
    set_eff(9'h010);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h010) begin
      $display("FAIL arst_pre got=%h want=%h", obs(), exp_vec());
      bad++;
    end
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs() !== {9'h000, 1'b0, 4'd15, 1'b0}) begin
      $display("FAIL arst_drop got=%h want=%h", obs(), {9'h000, 1'b0, 4'd15, 1'b0});
      bad++;
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    set_eff(9'h1FF);
    step();
    total++;
    if (obs() !== exp_vec() || Grant !== 9'h001) begin
      $display("FAIL arst_scan0 got=%h want=%h", obs(), exp_vec());
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_polarity();
    test_no_preempt_wrap();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
